ps2_key_ctrl: RTL and testbench

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_tick_counter.sv | 32 +++
 rtl/ps2_key_ctrl.sv | 127 ++++++++++++
 tb/tb_ps2_key_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state type and small helpers for the PS/2 key controller.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  function automatic logic is_break_state(input ps2_state_e s);
    return (s == ST_BRK) || (s == ST_EXT_BRK);
  endfunction

  // A make sets the flag, a break clears it, anything else keeps it.
  function automatic logic next_held(input logic held, input logic mk,
                                     input logic br, input logic match);
    return match ? (mk | (held & ~br)) : held;
  endfunction

endpackage

// File: rtl/ps2_tick_counter.sv
// Saturating cycle counter with clear and enable; tc_o is high while the count sits at MAX.
module ps2_tick_counter #(
  parameter int unsigned MAX = 10
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q;

  // Count up while enabled, hold at MAX instead of wrapping.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MAX_C)) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign tc_o = (cnt_q == MAX_C);

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder producing game controls (jump/start/duck).
// Optional typematic jump repeat is built only when KEY_AUTOREPEAT_EN is defined.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 50000,
  parameter int unsigned REPEAT_TICKS  = 5000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_err,
  output logic       jump_pulse,
  output logic       start_pulse,
  output logic       duck,
  output logic       up_held,
  output logic       down_held,
  output logic       err_pulse
);

  ps2_state_e state_q;
  logic up_q, down_q, space_q, enter_q;
  logic up_d, down_d, space_d, enter_d;
  logic jump_q, start_q, duck_q, err_q;
  logic is_prefix, make_ev, brk_ev;
  logic to_tc, rep_fire;

  ps2_tick_counter #(.MAX(TIMEOUT_TICKS)) u_timeout (
    .clk_in  (clk_in),
    .rst     (rst),
    .clear_i (byte_valid || (state_q == ST_IDLE)),
    .en_i    (1'b1),
    .tc_o    (to_tc)
  );

`ifdef KEY_AUTOREPEAT_EN
  logic rep_tc;

  // Restart the repeat interval on every fire so pulses land every REPEAT_TICKS cycles.
  ps2_tick_counter #(.MAX((REPEAT_TICKS > 1) ? REPEAT_TICKS - 1 : 1)) u_repeat (
    .clk_in  (clk_in),
    .rst     (rst),
    .clear_i (!up_q || rep_tc),
    .en_i    (up_q),
    .tc_o    (rep_tc)
  );
  assign rep_fire = up_q && up_d && rep_tc;
`else
  assign rep_fire = 1'b0;
`endif

  // Classify the incoming byte and work out next held flags.
  always_comb begin
    is_prefix = (byte_data == SC_EXT) || (byte_data == SC_BRK);
    make_ev   = byte_valid && !byte_err && !is_prefix && !is_break_state(state_q);
    brk_ev    = byte_valid && !byte_err && !is_prefix &&  is_break_state(state_q);
    up_d      = next_held(up_q,    make_ev, brk_ev, byte_data == SC_UP);
    down_d    = next_held(down_q,  make_ev, brk_ev, byte_data == SC_DOWN);
    space_d   = next_held(space_q, make_ev, brk_ev, byte_data == SC_SPACE);
    enter_d   = next_held(enter_q, make_ev, brk_ev, byte_data == SC_ENTER);
  end

  // Prefix FSM, timeout/error handling and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      space_q <= 1'b0;
      enter_q <= 1'b0;
      jump_q  <= 1'b0;
      start_q <= 1'b0;
      duck_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      up_q    <= up_d;
      down_q  <= down_d;
      space_q <= space_d;
      enter_q <= enter_d;
      duck_q  <= down_d && !up_d;
      jump_q  <= (make_ev && (((byte_data == SC_UP) && !up_q) ||
                              ((byte_data == SC_SPACE) && !space_q))) || rep_fire;
      start_q <= make_ev && (byte_data == SC_ENTER) && !enter_q;
      if (byte_valid) begin
        err_q <= byte_err;
        if (byte_err) begin
          state_q <= ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (byte_data == SC_EXT) begin
                state_q <= ST_EXT;
              end else if (byte_data == SC_BRK) begin
                state_q <= ST_BRK;
              end else begin
                state_q <= ST_IDLE;
              end
            end
            ST_EXT: begin
              if (byte_data == SC_BRK) begin
                state_q <= ST_EXT_BRK;
              end else begin
                state_q <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end else if ((state_q != ST_IDLE) && to_tc) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
      end else begin
        state_q <= state_q;
        err_q   <= 1'b0;
      end
    end
  end

  assign jump_pulse  = jump_q;
  assign start_pulse = start_q;
  assign duck        = duck_q;
  assign up_held     = up_q;
  assign down_held   = down_q;
  assign err_pulse   = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: stimulus queues expected output vectors, a monitor checks them.
module tb_ps2_key_ctrl;

  localparam int unsigned TO_T  = 20;
  localparam int unsigned REP_T = 16;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_err = 1'b0;
  logic       jump_pulse, start_pulse, duck, up_held, down_held, err_pulse;

  int n_checks = 0;
  int n_fail = 0;
  int jump_cnt = 0;
  logic [5:0] exp_q[$];
  logic [5:0] cur;
  logic [2:0] prev_lvl = 3'b000;

  always #5 clk_in = ~clk_in;

  ps2_key_ctrl #(.TIMEOUT_TICKS(TO_T), .REPEAT_TICKS(REP_T)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_err    (byte_err),
    .jump_pulse  (jump_pulse),
    .start_pulse (start_pulse),
    .duck        (duck),
    .up_held     (up_held),
    .down_held   (down_held),
    .err_pulse   (err_pulse)
  );

  // Vector layout: {jump, start, err, up_held, down_held, duck}
  function automatic logic [5:0] ev(input logic j, input logic s, input logic e,
                                    input logic u, input logic d, input logic k);
    return {j, s, e, u, d, k};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: any pulse or level change is a DUT event that must match the queue head.
  always @(negedge clk_in) begin
    cur = {jump_pulse, start_pulse, err_pulse, up_held, down_held, duck};
    if (jump_pulse === 1'b1) jump_cnt++;
    if ((cur[5:3] != 3'b000) || (cur[2:0] != prev_lvl)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {26'd0, cur}, 32'hFFFF_FFFF);
      end else begin
        check("event", {26'd0, cur}, {26'd0, exp_q.pop_front()});
      end
    end
    prev_lvl = cur[2:0];
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    @(negedge clk_in);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_err   = e;
    @(negedge clk_in);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    byte_data  = 8'hA5;
    idle(2);
  endtask

  task automatic expect_ev(input logic [5:0] v);
    exp_q.push_back(v);
  endtask

  int jc0;
  int exp_jumps;

  initial begin
    idle(3);
    check("reset_outputs", {26'd0, jump_pulse, start_pulse, err_pulse, up_held, down_held, duck}, 32'd0);
    rst = 1'b1;
    idle(2);

    // up make, typematic repeat, break
    expect_ev(ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); send(8'h75, 1'b0);
    send(8'h75, 1'b0);
    send(8'hF0, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); send(8'h75, 1'b0);

    // duck / jump priority with extended prefixes
    send(8'hE0, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)); send(8'h72, 1'b0);
    send(8'hE0, 1'b0);
    expect_ev(ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); send(8'h72, 1'b0);

    // space jumps, enter starts once per press
    expect_ev(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); send(8'h29, 1'b0);
    send(8'hF0, 1'b0); send(8'h29, 1'b0);
    expect_ev(ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); send(8'h5A, 1'b0);
    send(8'h5A, 1'b0);
    send(8'hF0, 1'b0); send(8'h5A, 1'b0);

    // timeout after a lone break prefix, then decoder is back in IDLE
    expect_ev(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); send(8'hF0, 1'b0);
    idle(TO_T + 10);
    expect_ev(ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); send(8'h5A, 1'b0);
    send(8'hF0, 1'b0); send(8'h5A, 1'b0);

    // unknown make/break and break of a non-held key are ignored
    send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h72, 1'b0);

    // framing error: byte dropped, held flags kept
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)); send(8'h72, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)); send(8'h75, 1'b1);
    send(8'hF0, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); send(8'h72, 1'b0);

    // reset between F0 and 75 aborts the break
    expect_ev(ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); send(8'h75, 1'b0);
    send(8'hF0, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk_in); rst = 1'b0;
    idle(3);
    check("reset_mid_seq", {26'd0, jump_pulse, start_pulse, err_pulse, up_held, down_held, duck}, 32'd0);
    rst = 1'b1;
    idle(1);
    expect_ev(ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); send(8'h75, 1'b0);
    send(8'hF0, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); send(8'h75, 1'b0);

    // hold up for 3 repeat periods
    jc0 = jump_cnt;
    expect_ev(ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef KEY_AUTOREPEAT_EN
    exp_jumps = 4;
    for (int i = 0; i < 3; i++) expect_ev(ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`else
    exp_jumps = 1;
`endif
    send(8'h75, 1'b0);
    idle(3 * REP_T);
    send(8'hF0, 1'b0);
    expect_ev(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); send(8'h75, 1'b0);
    idle(3);
    check("repeat_jump_count", jump_cnt - jc0, exp_jumps);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_in);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
